alu_muldiv: RTL and testbench

- Parametrised ALU for the MIPS datapath. It keeps the single-cycle logic ops and adds iterative multiply/divide into HI/LO registers, with a start/busy/done handshake.
- Sits in EX. The control unit holds the pipeline while busy is high.
- All results are registered.

---
 rtl/alu_muldiv.sv | 200 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// MIPS EX-stage ALU: registered single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide into HI/LO with start/busy/done.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluop,
    input  logic             start,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    // Handshake: start is sampled only at an edge where the FSM is IDLE; busy
    // is high while RUN/FIN; done is a one-cycle pulse after every accepted op.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOR = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;

    logic             is_md;
    logic             is_divop;
    logic             is_signed;
    logic             dz;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             ovf;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem_ext;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]   quo_step;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign is_md     = (aluop[3:2] == 2'b10);
    assign is_divop  = is_md && aluop[1];
    assign is_signed = !aluop[0];
    assign dz        = is_divop && (b == '0);
    assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
    assign busy      = (state != IDLE);

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (aluop)
            OP_ADD: begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_OR:  res = a | b;
            OP_AND: res = a & b;
            OP_NOT: res = ~a;
            OP_XOR: res = a ^ b;
            OP_NOR: res = ~(a | b);
            OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: res = '0;
        endcase
    end

    // One iteration on unsigned magnitudes. Multiply: acc:quo shifts right with
    // the multiplier consumed from quo[0]. Divide: the dividend shifts out of
    // quo's MSB into the partial remainder in acc; quotient bits enter at quo[0].
    always_comb begin
        mul_sum     = {1'b0, acc} + (quo[0] ? {1'b0, opnd} : '0);
        div_rem_ext = {acc, quo[WIDTH-1]};
        div_diff    = div_rem_ext - {1'b0, opnd};
        div_ge      = !div_diff[WIDTH];
        if (is_div) begin
            acc_step = div_ge ? div_diff[WIDTH-1:0] : div_rem_ext[WIDTH-1:0];
            quo_step = {quo[WIDTH-2:0], div_ge};
        end else begin
            acc_step = mul_sum[WIDTH:1];
            quo_step = {mul_sum[0], quo[WIDTH-1:1]};
        end
        prod     = {acc_step, quo_step};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -quo_step : quo_step;
        rem_fix  = neg_r ? -acc_step : acc_step;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && is_md && !dz) state_next = RUN;
            RUN:  if (cnt == CNT_W'(2)) state_next = FIN;
            FIN:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out         <= '0;
            zero        <= 1'b1;
            overflow    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            quo         <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!is_md) begin
                            out      <= res;
                            zero     <= (res == '0);
                            overflow <= ovf;
                            done     <= 1'b1;
                        end else if (dz) begin
                            // Zero divisor never enters RUN and leaves HI/LO intact.
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end else begin
                            acc    <= '0;
                            quo    <= a_mag;
                            opnd   <= b_mag;
                            is_div <= is_divop;
                            neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r  <= is_signed && a[WIDTH-1];
                            cnt    <= CNT_W'(WIDTH);
                            if (is_divop) div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    quo <= quo_step;
                    cnt <= cnt - CNT_W'(1);
                end
                FIN: begin
                    // The last iteration is folded into the sign-corrected write.
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done <= 1'b1;
                    cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: each accepted op pushes a full expected
// snapshot and completion cycle; the done monitor pops and compares.
module tb_alu_muldiv;

  localparam int W  = 32;
  localparam int EW = 3 * W + 3;

  typedef struct packed {
    logic [W-1:0] out;
    logic         zero;
    logic         ovf;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   aluop;
  logic         start;
  logic [W-1:0] out;
  logic         zero;
  logic         overflow;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .aluop(aluop), .start(start),
    .out(out), .zero(zero), .overflow(overflow), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  int            cyc_q[$];

  logic [W-1:0] m_out, m_hi, m_lo;
  logic         m_zero, m_ovf, m_dbz;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_hi = '0; m_lo = '0;
    m_zero = 1'b1; m_ovf = 1'b0; m_dbz = 1'b0;
  endtask

  exp_t mon_e;
  int   mon_c;
  always @(negedge clk) begin
    if (!reset && done) begin
      check("q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        check("done_cycle", cyc, mon_c);
        check("out", out, mon_e.out);
        check("zero", zero, mon_e.zero);
        check("overflow", overflow, mon_e.ovf);
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("div_by_zero", div_by_zero, mon_e.dbz);
        check("busy_at_done", busy, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; waits for the unit to be free, predicts, then strobes.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb);
    int n;
    logic md, dz;
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    logic [W:0] s;
    exp_t e;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_wait", busy, 0);
    md = (op[3:2] == 2'b10);
    dz = md && op[1] && (bb == '0);
    sa = $signed(aa);
    sb = $signed(bb);
    case (op)
      4'd0: begin s = {aa[W-1], aa} + {bb[W-1], bb}; m_out = s[W-1:0]; m_ovf = s[W] ^ s[W-1]; end
      4'd1: begin s = {aa[W-1], aa} - {bb[W-1], bb}; m_out = s[W-1:0]; m_ovf = s[W] ^ s[W-1]; end
      4'd2: begin m_out = aa | bb;    m_ovf = 1'b0; end
      4'd3: begin m_out = aa & bb;    m_ovf = 1'b0; end
      4'd4: begin m_out = ~aa;        m_ovf = 1'b0; end
      4'd5: begin m_out = aa ^ bb;    m_ovf = 1'b0; end
      4'd6: begin m_out = ~(aa | bb); m_ovf = 1'b0; end
      4'd7: begin m_out = (sa < sb) ? 32'd1 : 32'd0; m_ovf = 1'b0; end
      4'd8: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd9: begin p = {32'd0, aa} * {32'd0, bb}; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd10, 4'd11: begin
        if (dz) m_dbz = 1'b1;
        else begin
          m_dbz = 1'b0;
          if (op == 4'd10) begin
            p = sa / sb; m_lo = p[31:0];
            p = sa % sb; m_hi = p[31:0];
          end else begin
            m_lo = aa / bb;
            m_hi = aa % bb;
          end
        end
      end
      default: begin m_out = '0; m_ovf = 1'b0; end
    endcase
    if (!md) m_zero = (m_out == '0);
    e = '{out: m_out, zero: m_zero, ovf: m_ovf, hi: m_hi, lo: m_lo, dbz: m_dbz};
    exp_q.push_back(e);
    cyc_q.push_back(cyc + 1 + ((md && !dz) ? W : 0));
    aluop = op; a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    aluop = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
  endtask

  // Strobe without prediction: used only while the unit is busy.
  task automatic poke(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb);
    aluop = op; a = aa; b = bb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; aluop = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_out", out, 0);
    check("rst_zero", zero, 1);
    check("rst_ovf", overflow, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    reset = 1'b0;
    @(negedge clk);

    issue(4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(4'd1, 32'd5, 32'd5);
    issue(4'd1, 32'h8000_0000, 32'd1);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    issue(4'd7, 32'd1, 32'hFFFF_FFFF);
    issue(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int op = 2; op <= 6; op++) issue(4'(op), $urandom, $urandom);

    issue(4'd8, 32'hFFFF_FFFD, 32'd7);
    repeat (3) @(negedge clk);
    poke(4'd0, 32'd1, 32'd1);
    issue(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'd11, 32'd100, 32'd7);
    issue(4'd10, 32'hFFFF_FFF9, 32'd2);
    issue(4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(4'd11, 32'd7, 32'd0);
    issue(4'd10, 32'd9, 32'd0);
    issue(4'd10, 32'h0000_0007, 32'hFFFF_FFFE);

    for (int i = 0; i < 24; i++)
      issue(4'($urandom_range(0, 15)), $urandom, (i % 5 == 0) ? 32'd0 : $urandom);

    // Reset in the middle of a multiply: nothing of it may survive.
    issue(4'd8, 32'h0001_2345, 32'h0000_0777);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_hi", hi, 0);
    check("mid_lo", lo, 0);
    check("mid_out", out, 0);
    check("mid_zero", zero, 1);
    reset = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    model_reset();
    issue(4'd0, 32'd2, 32'd3);

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
